fetch_btb: RTL and testbench
============================

# fetch_btb

Fetch-stage PC generator with a direct-mapped branch target buffer (BTB), sitting upstream of the hazard unit's branch unit. It holds the PC, predicts the next PC from the BTB, and carries each fetched instruction's BTB lookup (`PcMatchValid`, 2-bit counter) through IF/ID and ID/EX shadow registers so the branch unit sees it in EX. It applies the branch unit's redirect (`NPC`) and counter write-back (`CtrlOut`/`WriteEnable`), and obeys the stall unit's PC/pipeline stall and flush signals.

## Interface
- `ENTRIES`, 16 — BTB entries, power of two ≥ 2; `IDX_W = $clog2(ENTRIES)`.
- `PC_W`, 32 — PC width.
- `RESET_PC`, 0 — PC after reset.

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — reset, synchronous, active-high.
- `i_PC_Stall` in 1 — hold PC.
- `i_IFID_Stall`, `i_IDEX_Stall` in 1 — hold the shadow registers.
- `i_Flush_IF_ID`, `i_Flush_ID_EX` in 1 — clear the shadow registers.
- `i_NPC` in 2 — redirect select from the branch unit.
- `i_Resolve_Target` in PC_W — resolved branch/jump target of the EX instruction.
- `i_WriteEnable` in 1 — BTB update strobe.
- `i_CtrlOut` in 2 — new counter value.
- `o_PC` out PC_W — fetch PC.
- `o_EX_PC` out PC_W — PC of the EX instruction.
- `o_EX_PcMatchValid` out 1 — BTB hit recorded at fetch.
- `o_EX_CtrlIn` out 2 — counter recorded at fetch.

## Operation
- Entry fields: `valid`, `tag = PC[PC_W-1:IDX_W+2]`, `target[PC_W]`, `ctrl[2]`. Index is `PC[IDX_W+1:2]`.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. Predicted taken is `ctrl[1]`.
- Lookup on `o_PC` is combinational. `hit = valid & tag match`.
- Next-PC priority:
  1. `rst` → `RESET_PC`.
  2. `i_NPC == 2'b01` → `i_Resolve_Target`.
  3. `i_NPC == 2'b10` → `o_EX_PC + 4`.
  4. `i_PC_Stall` → hold.
  5. `hit & ctrl[1]` → entry target.
  6. Otherwise `o_PC + 4`.
- `i_NPC` values 00 and 11 mean no redirect. A redirect overrides `i_PC_Stall`.
- PC arithmetic is modulo 2^PC_W; `+4` wraps silently.
- IF/ID shadow register holds {PC, hit, ctrl}.
  - `rst` or `i_Flush_IF_ID` → all zero.
  - Else if `!i_IFID_Stall`, it loads the current lookup.
  - Else it holds.
- ID/EX shadow register behaves the same, using `i_Flush_ID_EX`/`i_IDEX_Stall` and loading from IF/ID.
- In both shadow registers, flush has priority over stall.
- On miss, the captured ctrl is 00.
- Update on `i_WriteEnable`: entry at `o_EX_PC` index gets `valid=1`, tag of `o_EX_PC`, `target=i_Resolve_Target`, `ctrl=i_CtrlOut`. A miss overwrites (allocates).
- Same-cycle update and lookup on the same index: the lookup sees pre-write contents. There is no bypass.
- `rst` clears all valid bits in one cycle. Targets and counters are not reset.

## Timing
- Values after reset: `o_PC=RESET_PC`; `o_EX_PC=0`; `o_EX_PcMatchValid=0`; `o_EX_CtrlIn=00`; all BTB entries invalid.
- Prediction has zero-cycle latency: a hit-taken fetch at cycle n gives target PC at n+1.
- Lookup data of the instruction fetched at n appears on `o_EX_*` at n+2 when there are no stalls.
- An update at cycle n is visible to lookups from n+1.
- Redirect applied at n: `o_PC` is the new value at n+1.
- Reset mid-operation discards the pending redirect and update.

## Configuration
- `FETCH_BTB_EN` defined: the BTB is built as above.
- Undefined:
  - No table storage.
  - `hit` is always 0; next PC is only reset/redirect/hold/`+4`.
  - Shadow registers carry `hit=0`, `ctrl=00`.
  - `i_WriteEnable`/`i_CtrlOut` are ignored.

## Structure
- Shared package `fetch_pkg`:
  - NPC encodings `NPC_SEQ=2'b00`, `NPC_TARGET=2'b01`, `NPC_RECOVER=2'b10`.
  - Counter constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - BTB entry struct typedef.
- One sub-module `btb_table`: storage, lookup, update, valid reset, parameterised by `ENTRIES`/`PC_W`. It is instantiated only under `FETCH_BTB_EN`.
- PC register and shadow registers live in the top level.

## Test plan
- **Reset:** assert `rst` for 2 cycles, `RESET_PC=0x100` → `o_PC=0x100`, `o_EX_*` zero, next cycle `o_PC=0x104`.
- **Update then hit:** `o_EX_PC=0x108`, `i_WriteEnable=1`, `i_CtrlOut=10`, target `0x400` → on the next fetch of `0x108`, next `o_PC=0x400`. Two cycles later `o_EX_PcMatchValid=1`, `o_EX_CtrlIn=10`.
- **Misprediction recovery:** `i_NPC=10` with `o_EX_PC=0x108` while `i_PC_Stall=1` → `o_PC=0x10C` next cycle; flushed shadow registers read zero.
- **Stall:** `i_PC_Stall=1` for 3 cycles at `0x200`, `i_IFID_Stall=1` → `o_PC` stays `0x200` and IF/ID contents are held. With IF/ID held, `i_Flush_IF_ID=1` in the same cycle clears IF/ID; flush wins.
- **Aliasing:** with `ENTRIES=16`, entry written for `0x108`; fetch `0x148` (same index, different tag) → miss, `o_PC=0x14C`.
- **Same-cycle write/read:** update and fetch of `0x108` in the same cycle → fetch uses the old (miss) result, so next `o_PC=0x10C`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage: redirect selects, 2-bit counters, BTB entry metadata.
package fetch_pkg;
    localparam logic [1:0] NPC_SEQ     = 2'b00;
    localparam logic [1:0] NPC_TARGET  = 2'b01;
    localparam logic [1:0] NPC_RECOVER = 2'b10;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctrl;
    } btb_meta_t;
endpackage

// File: rtl/fetch_btb_table.sv
// Direct-mapped BTB storage: combinational lookup, registered update, one-cycle valid clear.
// Lookup on the same index as a same-cycle update returns the pre-write contents.
module btb_table
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic [1:0]      lookup_ctrl,
    output logic [PC_W-1:0] lookup_target,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic [1:0]      upd_ctrl
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    btb_meta_t [ENTRIES-1:0] meta_q, meta_d;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [PC_W-1:0]         target_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             unused_low_bits;

    assign rd_idx = lookup_pc[IDX_W+1:2];
    assign rd_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[PC_W-1:IDX_W+2];
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lookup_hit    = meta_q[rd_idx].valid && (tag_q[rd_idx] == rd_tag);
    assign lookup_ctrl   = lookup_hit ? meta_q[rd_idx].ctrl : CTR_SNT;
    assign lookup_target = target_q[rd_idx];

    // Reset drops only the valid bits; counters keep their stale values.
    always_comb begin
        meta_d = meta_q;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_d[i].valid = 1'b0;
            end
        end else if (upd_en) begin
            meta_d[wr_idx] = '{valid: 1'b1, ctrl: upd_ctrl};
        end
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        if (!rst && upd_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= upd_target;
        end
    end
endmodule

// File: rtl/fetch_btb.sv
// Fetch PC generator with optional BTB prediction (enabled by FETCH_BTB_EN) and IF/ID, ID/EX
// shadow registers carrying each fetch's BTB lookup down to the branch unit in EX.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int              ENTRIES  = 16,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_PC_Stall,
    input  logic            i_IFID_Stall,
    input  logic            i_IDEX_Stall,
    input  logic            i_Flush_IF_ID,
    input  logic            i_Flush_ID_EX,
    input  logic [1:0]      i_NPC,
    input  logic [PC_W-1:0] i_Resolve_Target,
    input  logic            i_WriteEnable,
    input  logic [1:0]      i_CtrlOut,
    output logic [PC_W-1:0] o_PC,
    output logic [PC_W-1:0] o_EX_PC,
    output logic            o_EX_PcMatchValid,
    output logic [1:0]      o_EX_CtrlIn
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
    logic            ifid_hit_q, ifid_hit_d, idex_hit_q, idex_hit_d;
    logic [1:0]      ifid_ctrl_q, ifid_ctrl_d, idex_ctrl_q, idex_ctrl_d;

    logic            lk_hit;
    logic [1:0]      lk_ctrl;
    logic [PC_W-1:0] lk_target;

`ifdef FETCH_BTB_EN
    btb_table #(.ENTRIES(ENTRIES), .PC_W(PC_W)) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (pc_q),
        .lookup_hit    (lk_hit),
        .lookup_ctrl   (lk_ctrl),
        .lookup_target (lk_target),
        .upd_en        (i_WriteEnable),
        .upd_pc        (idex_pc_q),
        .upd_target    (i_Resolve_Target),
        .upd_ctrl      (i_CtrlOut)
    );
`else
    logic [$clog2(ENTRIES)-1:0] unused_idx;
    logic                       unused_upd;
    assign unused_idx = idex_pc_q[$clog2(ENTRIES)+1:2];
    assign unused_upd = ^{i_WriteEnable, i_CtrlOut, unused_idx};
    assign lk_hit     = 1'b0;
    assign lk_ctrl    = CTR_SNT;
    assign lk_target  = '0;
`endif

    // Branch-unit redirects win over a PC stall; prediction only applies to free-running fetch.
    always_comb begin
        pc_d = pc_q + PC_W'(4);
        case (i_NPC)
            NPC_TARGET:  pc_d = i_Resolve_Target;
            NPC_RECOVER: pc_d = idex_pc_q + PC_W'(4);
            default: begin
                if (i_PC_Stall) begin
                    pc_d = pc_q;
                end else if (lk_hit && lk_ctrl[1]) begin
                    pc_d = lk_target;
                end
            end
        endcase
    end

    always_comb begin
        ifid_pc_d   = ifid_pc_q;
        ifid_hit_d  = ifid_hit_q;
        ifid_ctrl_d = ifid_ctrl_q;
        idex_pc_d   = idex_pc_q;
        idex_hit_d  = idex_hit_q;
        idex_ctrl_d = idex_ctrl_q;
        if (i_Flush_IF_ID) begin
            ifid_pc_d   = '0;
            ifid_hit_d  = 1'b0;
            ifid_ctrl_d = CTR_SNT;
        end else if (!i_IFID_Stall) begin
            ifid_pc_d   = pc_q;
            ifid_hit_d  = lk_hit;
            ifid_ctrl_d = lk_ctrl;
        end
        if (i_Flush_ID_EX) begin
            idex_pc_d   = '0;
            idex_hit_d  = 1'b0;
            idex_ctrl_d = CTR_SNT;
        end else if (!i_IDEX_Stall) begin
            idex_pc_d   = ifid_pc_q;
            idex_hit_d  = ifid_hit_q;
            idex_ctrl_d = ifid_ctrl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ifid_pc_q   <= '0;
            ifid_hit_q  <= 1'b0;
            ifid_ctrl_q <= CTR_SNT;
            idex_pc_q   <= '0;
            idex_hit_q  <= 1'b0;
            idex_ctrl_q <= CTR_SNT;
        end else begin
            pc_q        <= pc_d;
            ifid_pc_q   <= ifid_pc_d;
            ifid_hit_q  <= ifid_hit_d;
            ifid_ctrl_q <= ifid_ctrl_d;
            idex_pc_q   <= idex_pc_d;
            idex_hit_q  <= idex_hit_d;
            idex_ctrl_q <= idex_ctrl_d;
        end
    end

    assign o_PC              = pc_q;
    assign o_EX_PC           = idex_pc_q;
    assign o_EX_PcMatchValid = idex_hit_q;
    assign o_EX_CtrlIn       = idex_ctrl_q;
endmodule

// File: tb/tb_fetch_btb.sv
// Bench for fetch_btb: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of PC selection, shadow pipe and BTB.
module tb_fetch_btb;
    localparam int          ENTRIES = 16;
    localparam int          PC_W    = 32;
    localparam int          IDX_W   = 4;
    localparam logic [31:0] RST_PC  = 32'h100;
`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stall, ifid_stall, idex_stall, flush_ifid, flush_idex;
    logic [1:0]  npc;
    logic [31:0] res_tgt;
    logic        we;
    logic [1:0]  ctrl_out;
    logic [31:0] o_pc, o_ex_pc;
    logic        o_ex_hit;
    logic [1:0]  o_ex_ctrl;

    fetch_btb #(.ENTRIES(ENTRIES), .PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_PC_Stall        (pc_stall),
        .i_IFID_Stall      (ifid_stall),
        .i_IDEX_Stall      (idex_stall),
        .i_Flush_IF_ID     (flush_ifid),
        .i_Flush_ID_EX     (flush_idex),
        .i_NPC             (npc),
        .i_Resolve_Target  (res_tgt),
        .i_WriteEnable     (we),
        .i_CtrlOut         (ctrl_out),
        .o_PC              (o_pc),
        .o_EX_PC           (o_ex_pc),
        .o_EX_PcMatchValid (o_ex_hit),
        .o_EX_CtrlIn       (o_ex_ctrl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: fetch PC, two pipeline slots, and a table of remembered writer PCs.
    logic [31:0] m_pc, m_if_pc, m_ex_pc;
    logic        m_if_hit, m_ex_hit;
    logic [1:0]  m_if_ctrl, m_ex_ctrl;
    bit          m_valid  [ENTRIES];
    logic [31:0] m_src_pc [ENTRIES];
    logic [31:0] m_tgt    [ENTRIES];
    logic [1:0]  m_ctr    [ENTRIES];
    logic [31:0] mn_pc, mt;
    logic        mh;
    logic [1:0]  mc;
    int          mk;

    always @(posedge clk) begin
        mh = 1'b0; mc = 2'b00; mt = '0;
        if (BTB_ON) begin
            mk = int'((m_pc >> 2) % ENTRIES);
            if (m_valid[mk] && (m_src_pc[mk] >> (IDX_W + 2)) == (m_pc >> (IDX_W + 2))) begin
                mh = 1'b1; mc = m_ctr[mk]; mt = m_tgt[mk];
            end
        end
        if (rst) begin
            m_pc = RST_PC;
            m_if_pc = '0; m_if_hit = 1'b0; m_if_ctrl = 2'b00;
            m_ex_pc = '0; m_ex_hit = 1'b0; m_ex_ctrl = 2'b00;
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else begin
            if (npc == 2'd1)                mn_pc = res_tgt;
            else if (npc == 2'd2)           mn_pc = m_ex_pc + 32'd4;
            else if (pc_stall)              mn_pc = m_pc;
            else if (mh && mc[1])           mn_pc = mt;
            else                            mn_pc = m_pc + 32'd4;
            if (BTB_ON && we) begin
                mk = int'((m_ex_pc >> 2) % ENTRIES);
                m_valid[mk] = 1'b1; m_src_pc[mk] = m_ex_pc; m_tgt[mk] = res_tgt; m_ctr[mk] = ctrl_out;
            end
            if (flush_idex) begin
                m_ex_pc = '0; m_ex_hit = 1'b0; m_ex_ctrl = 2'b00;
            end else if (!idex_stall) begin
                m_ex_pc = m_if_pc; m_ex_hit = m_if_hit; m_ex_ctrl = m_if_ctrl;
            end
            if (flush_ifid) begin
                m_if_pc = '0; m_if_hit = 1'b0; m_if_ctrl = 2'b00;
            end else if (!ifid_stall) begin
                m_if_pc = m_pc; m_if_hit = mh; m_if_ctrl = mc;
            end
            m_pc = mn_pc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model o_PC", o_pc, m_pc);
            check("model o_EX_PC", o_ex_pc, m_ex_pc);
            check("model o_EX_PcMatchValid", 32'(o_ex_hit), 32'(m_ex_hit));
            check("model o_EX_CtrlIn", 32'(o_ex_ctrl), 32'(m_ex_ctrl));
        end
    end

    task automatic clear_inputs();
        rst = 1'b0; pc_stall = 1'b0; ifid_stall = 1'b0; idex_stall = 1'b0;
        flush_ifid = 1'b0; flush_idex = 1'b0; npc = 2'b00; res_tgt = '0;
        we = 1'b0; ctrl_out = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        npc = 2'b01; res_tgt = tgt;
        step();
        npc = 2'b00; res_tgt = '0;
    endtask

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_src_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b00;
        end
        clear_inputs();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("reset o_PC", o_pc, 32'h100);
        check("reset o_EX_PC", o_ex_pc, 32'h0);
        check("reset o_EX_PcMatchValid", 32'(o_ex_hit), 32'h0);
        check("reset o_EX_CtrlIn", 32'(o_ex_ctrl), 32'h0);
        rst = 1'b0;
        step();
        check("seq after reset", o_pc, 32'h104);
        step(); step(); step();
        check("ex pc pipeline", o_ex_pc, 32'h108);

        // Hold 0x108 in EX, fetch 0x108, then write its entry in the same cycle as that fetch.
        idex_stall = 1'b1;
        redirect(32'h108);
        check("redirect target", o_pc, 32'h108);
        we = 1'b1; ctrl_out = 2'b10; res_tgt = 32'h400;
        step();
        check("same-cycle write sees miss", o_pc, 32'h10C);
        clear_inputs();
        redirect(32'h108);
        step();
        check("hit-taken predicts target", o_pc, BTB_ON ? 32'h400 : 32'h10C);
        step();
        check("ex pc of hit fetch", o_ex_pc, 32'h108);
        check("ex match valid", 32'(o_ex_hit), BTB_ON ? 32'h1 : 32'h0);
        check("ex ctrl", 32'(o_ex_ctrl), BTB_ON ? 32'h2 : 32'h0);

        npc = 2'b10; pc_stall = 1'b1; flush_ifid = 1'b1; flush_idex = 1'b1;
        step();
        check("recover overrides stall", o_pc, 32'h10C);
        check("recover flush ex pc", o_ex_pc, 32'h0);
        check("recover flush ex hit", 32'(o_ex_hit), 32'h0);
        clear_inputs();

        redirect(32'h200);
        pc_stall = 1'b1; ifid_stall = 1'b1;
        step(); step(); step();
        check("pc held under stall", o_pc, 32'h200);
        check("ifid held under stall", o_ex_pc, 32'h10C);
        flush_ifid = 1'b1;
        step();
        clear_inputs();
        step();
        check("flush beats stall", o_ex_pc, 32'h0);
        check("seq after stall", o_pc, 32'h204);

        redirect(32'h148);
        step();
        check("alias index misses", o_pc, 32'h14C);

        redirect(32'hFFFF_FFFC);
        step();
        check("pc wraps", o_pc, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            npc        = (r < 80) ? 2'b00 : (r < 88) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
            res_tgt    = ($urandom_range(0, 9) == 0) ? {$urandom(), 2'b00}
                                                     : {22'h0, 8'($urandom_range(32'h40, 32'h7F)), 2'b00};
            pc_stall   = ($urandom_range(0, 4) == 0);
            ifid_stall = ($urandom_range(0, 6) == 0);
            idex_stall = ($urandom_range(0, 6) == 0);
            flush_ifid = ($urandom_range(0, 9) == 0);
            flush_idex = ($urandom_range(0, 9) == 0);
            we         = ($urandom_range(0, 2) == 0);
            ctrl_out   = 2'($urandom_range(0, 3));
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
